// File: rtl/ahb_print_master.sv
// AHB-lite master that drains a character FIFO into single-beat byte writes
// at a fixed print-buffer address, with wait-state and two-cycle ERROR handling.
module ahb_print_master #(
    parameter logic [31:0] TARGET_ADDR = 32'h5000_0000,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    input  logic                          enable,
    output logic [31:0]                   HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [3:0]                    HPROT,
    output logic [31:0]                   HWDATA,
    input  logic                          HREADY,
    input  logic                          HRESP,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]   level_q, level_d;
    logic        aValid_q, aValid_d, dValid_q, dValid_d, aRetry_q, aRetry_d;
    logic [7:0]  aByte_q, aByte_d, dByte_q, dByte_d;
    logic [7:0]  errCnt_q, errCnt_d;
    logic        full, empty, push, pop, errFirst;

    assign full     = (level_q == (AW+1)'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign in_ready = !full && !HRESET;
    assign push     = in_valid && in_ready;
    assign pop      = HREADY && enable && !empty && !aRetry_q;
    assign errFirst = dValid_q && HRESP && !HREADY;

    assign HADDR      = TARGET_ADDR;
    assign HTRANS     = aValid_q ? 2'b10 : 2'b00;
    assign HWRITE     = 1'b1;
    assign HSIZE      = 3'b000;
    assign HBURST     = 3'b000;
    assign HPROT      = 4'b0011;
    assign HWDATA     = {4{dByte_q}};
    assign busy       = !empty || aValid_q || dValid_q || aRetry_q;
    assign fifo_level = level_q;
    assign err_count  = errCnt_q;

    always_ff @(posedge HCLK) begin
        if (push) mem_q[wrPtr_q] <= in_data;
    end

    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        level_d  = level_q;
        aValid_d = aValid_q;
        aByte_d  = aByte_q;
        dValid_d = dValid_q;
        dByte_d  = dByte_q;
        aRetry_d = aRetry_q;
        errCnt_d = errCnt_q;

        if (push) wrPtr_d = wrPtr_q + AW'(1);
        if (pop)  rdPtr_d = rdPtr_q + AW'(1);
        if (push && !pop)      level_d = level_q + (AW+1)'(1);
        else if (!push && pop) level_d = level_q - (AW+1)'(1);

        // The first ERROR cycle cancels the pending address phase so the bus
        // sees IDLE next; the cancelled byte is replayed once the error ends.
        if (errFirst) begin
            aRetry_d = aValid_q;
            aValid_d = 1'b0;
            if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
        end else if (HREADY) begin
            dValid_d = aValid_q;
            dByte_d  = aByte_q;
            if (aRetry_q) begin
                aValid_d = 1'b1;
                aRetry_d = 1'b0;
            end else begin
                aValid_d = pop;
                if (pop) aByte_d = mem_q[rdPtr_q];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            level_q  <= '0;
            aValid_q <= 1'b0;
            aByte_q  <= 8'h00;
            dValid_q <= 1'b0;
            dByte_q  <= 8'h00;
            aRetry_q <= 1'b0;
            errCnt_q <= 8'h00;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            level_q  <= level_d;
            aValid_q <= aValid_d;
            aByte_q  <= aByte_d;
            dValid_q <= dValid_d;
            dByte_q  <= dByte_d;
            aRetry_q <= aRetry_d;
            errCnt_q <= errCnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_print_master.sv
// Directed bench for ahb_print_master: a small AHB slave monitor records every
// completed write so byte order, drops and replays can be checked.
module tb_ahb_print_master;

    logic        HCLK = 1'b0;
    logic        HRESET, in_valid, enable, HREADY, HRESP;
    logic [7:0]  in_data;
    logic        in_ready, HWRITE, busy;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [4:0]  fifo_level;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] capQ[$];
    logic [7:0] expQ[$];
    int errSeen = 0;
    logic dataPending = 1'b0;

    ahb_print_master dut (
        .HCLK(HCLK), .HRESET(HRESET), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .enable(enable), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .busy(busy),
        .fifo_level(fifo_level), .err_count(err_count)
    );

    always #5 HCLK = ~HCLK;

    // Slave-side view of the bus, evaluated half a cycle before each rising
    // edge: completes data phases and accepts NONSEQ address phases.
    always @(negedge HCLK) begin
        if (HRESET) begin
            dataPending = 1'b0;
        end else if (HREADY) begin
            if (dataPending) begin
                if (HRESP) errSeen++;
                else       capQ.push_back(HWDATA[7:0]);
            end
            dataPending = (HTRANS == 2'b10);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkCaptures(input string tag);
        checkOutput({tag, "_count"}, 32'(capQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, capQ[i]}, {24'h0, expQ[i]});
        capQ.delete();
        expQ.delete();
    endtask

    initial begin
        HRESET = 1'b1; enable = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
        applyStimulus(1'b0, 8'h00);
        tick(); tick();
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("rst_htrans", {30'h0, HTRANS}, 32'h0);
        checkOutput("rst_hwdata", HWDATA, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_level", {27'h0, fifo_level}, 32'h0);
        checkOutput("rst_errcnt", {24'h0, err_count}, 32'h0);
        checkOutput("const_haddr", HADDR, 32'h5000_0000);
        checkOutput("const_ctrl", {20'h0, HWRITE, HSIZE, HBURST, HPROT}, {20'h0, 1'b1, 3'b000, 3'b000, 4'b0011});
        HRESET = 1'b0;
        #1;
        checkOutput("rel_in_ready", {31'h0, in_ready}, 32'h1);
        capQ.delete();

        // Single byte through an idle pipeline
        applyStimulus(1'b1, 8'h41);
        tick();
        applyStimulus(1'b0, 8'h00);
        checkOutput("single_level", {27'h0, fifo_level}, 32'd1);
        checkOutput("single_busy", {31'h0, busy}, 32'h1);
        checkOutput("single_idle_e0", {30'h0, HTRANS}, 32'h0);
        tick();
        checkOutput("single_nonseq", {30'h0, HTRANS}, 32'h2);
        tick();
        checkOutput("single_idle_e2", {30'h0, HTRANS}, 32'h0);
        checkOutput("single_hwdata", HWDATA, 32'h4141_4141);
        checkOutput("single_busy_e2", {31'h0, busy}, 32'h1);
        tick();
        checkOutput("single_busy_e3", {31'h0, busy}, 32'h0);
        expQ = '{8'h41};
        checkCaptures("single");

        // Fill past capacity against a stalled slave
        HREADY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i));
            tick();
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("full_level", {27'h0, fifo_level}, 32'd16);
        checkOutput("full_in_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("full_no_nonseq", {30'h0, HTRANS}, 32'h0);
        HREADY = 1'b1;
        tick();
        checkOutput("drain_level1", {27'h0, fifo_level}, 32'd15);
        checkOutput("drain_nonseq", {30'h0, HTRANS}, 32'h2);
        checkOutput("drain_in_ready", {31'h0, in_ready}, 32'h1);
        for (int i = 0; i < 16; i++) tick();
        checkOutput("drain_busy_r17", {31'h0, busy}, 32'h1);
        tick();
        checkOutput("drain_busy_r18", {31'h0, busy}, 32'h0);
        checkOutput("drain_level0", {27'h0, fifo_level}, 32'd0);
        for (int i = 0; i < 16; i++) expQ.push_back(8'h10 + 8'(i));
        checkCaptures("drain");

        // Two wait states in the data phase of the middle byte
        applyStimulus(1'b1, 8'h31); tick();
        applyStimulus(1'b1, 8'h32); tick();
        applyStimulus(1'b1, 8'h33); tick();
        applyStimulus(1'b0, 8'h00); tick();
        HREADY = 1'b0;
        checkOutput("wait_hwdata0", HWDATA, 32'h3232_3232);
        checkOutput("wait_htrans0", {30'h0, HTRANS}, 32'h2);
        tick();
        checkOutput("wait_hwdata1", HWDATA, 32'h3232_3232);
        checkOutput("wait_htrans1", {30'h0, HTRANS}, 32'h2);
        tick();
        checkOutput("wait_hwdata2", HWDATA, 32'h3232_3232);
        checkOutput("wait_htrans2", {30'h0, HTRANS}, 32'h2);
        HREADY = 1'b1;
        tick();
        checkOutput("wait_hwdata3", HWDATA, 32'h3333_3333);
        checkOutput("wait_idle", {30'h0, HTRANS}, 32'h0);
        tick(); tick();
        checkOutput("wait_busy", {31'h0, busy}, 32'h0);
        expQ = '{8'h31, 8'h32, 8'h33};
        checkCaptures("wait");

        // Two-cycle ERROR on 0x48 while 0x49 sits in its address phase
        applyStimulus(1'b1, 8'h48); tick();
        applyStimulus(1'b1, 8'h49); tick();
        applyStimulus(1'b0, 8'h00); tick();
        HRESP = 1'b1; HREADY = 1'b0;
        checkOutput("err_x_hwdata", HWDATA, 32'h4848_4848);
        checkOutput("err_x_htrans", {30'h0, HTRANS}, 32'h2);
        tick();
        HREADY = 1'b1;
        checkOutput("err_x1_idle", {30'h0, HTRANS}, 32'h0);
        checkOutput("err_x1_count", {24'h0, err_count}, 32'd1);
        checkOutput("err_x1_busy", {31'h0, busy}, 32'h1);
        tick();
        HRESP = 1'b0;
        checkOutput("err_x2_retry", {30'h0, HTRANS}, 32'h2);
        tick();
        checkOutput("err_retry_hwdata", HWDATA, 32'h4949_4949);
        checkOutput("err_retry_idle", {30'h0, HTRANS}, 32'h0);
        tick();
        checkOutput("err_busy", {31'h0, busy}, 32'h0);
        checkOutput("err_count_final", {24'h0, err_count}, 32'd1);
        checkOutput("err_slave_seen", 32'(errSeen), 32'd1);
        expQ = '{8'h49};
        checkCaptures("err");

        // Gating with four bytes queued
        enable = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i));
            tick();
        end
        applyStimulus(1'b0, 8'h00);
        tick(); tick();
        checkOutput("gate_level", {27'h0, fifo_level}, 32'd4);
        checkOutput("gate_idle", {30'h0, HTRANS}, 32'h0);
        checkOutput("gate_busy", {31'h0, busy}, 32'h1);
        enable = 1'b1;
        tick();
        checkOutput("gate_nonseq", {30'h0, HTRANS}, 32'h2);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("gate_done_busy", {31'h0, busy}, 32'h0);
        checkOutput("gate_last_hwdata", HWDATA, 32'h0404_0404);
        expQ = '{8'h01, 8'h02, 8'h03, 8'h04};
        checkCaptures("gate");

        // Reset in the middle of a data phase
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h61 + 8'(i));
            tick();
        end
        applyStimulus(1'b0, 8'h00);
        enable = 1'b1;
        tick(); tick();
        checkOutput("mrst_pre_level", {27'h0, fifo_level}, 32'd3);
        checkOutput("mrst_pre_hwdata", HWDATA, 32'h6161_6161);
        HRESET = 1'b1;
        #1;
        checkOutput("mrst_in_ready", {31'h0, in_ready}, 32'h0);
        tick();
        checkOutput("mrst_idle", {30'h0, HTRANS}, 32'h0);
        checkOutput("mrst_level", {27'h0, fifo_level}, 32'd0);
        checkOutput("mrst_errcnt", {24'h0, err_count}, 32'd0);
        checkOutput("mrst_hwdata", HWDATA, 32'h0);
        checkOutput("mrst_busy", {31'h0, busy}, 32'h0);
        HRESET = 1'b0;
        expQ.delete();
        checkCaptures("mrst_abandon");
        applyStimulus(1'b1, 8'h5A); tick();
        applyStimulus(1'b0, 8'h00);
        tick();
        checkOutput("mrst_new_nonseq", {30'h0, HTRANS}, 32'h2);
        tick();
        checkOutput("mrst_new_hwdata", HWDATA, 32'h5A5A_5A5A);
        tick();
        checkOutput("mrst_new_busy", {31'h0, busy}, 32'h0);
        expQ = '{8'h5A};
        checkCaptures("mrst_new");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_print_master.md
# ahb_print_master

AHB-lite master that accepts console characters on a valid/ready byte stream, buffers them in a small FIFO, and issues one single-beat byte write per character to the print-buffer slave at `TARGET_ADDR`. It sits directly upstream of the print buffer and replaces CPU stores as the character source, for example for trace or boot-log injection. It handles address/data-phase pipelining, wait states, and two-cycle ERROR responses.

## Interface
- `TARGET_ADDR`, default 32'h5000_0000: write address, driven constant on `HADDR`; bits [7:0] = 0.
- `FIFO_DEPTH`, default 16: character FIFO entries; must be a power of 2 and ≥2.
- `HCLK`  in  1  the single clock; all logic is on its rising edge.
- `HRESET`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  character available.
- `in_data`  in  8  character.
- `in_ready`  out  1  FIFO can accept; equals `!full && !HRESET`.
- `enable`  in  1  when low, no new FIFO pops; in-flight transfers complete.
- `HADDR`  out  32  constant `TARGET_ADDR`.
- `HTRANS`  out  2  2'b10 (NONSEQ) when an address phase is active, else 2'b00 (IDLE).
- `HWRITE`  out  1  constant 1.
- `HSIZE`  out  3  constant 3'b000 (byte).
- `HBURST`  out  3  constant 3'b000 (SINGLE).
- `HPROT`  out  4  constant 4'b0011.
- `HWDATA`  out  32  `{4{d_byte}}`; the byte is replicated on all lanes.
- `HREADY`  in  1  bus ready.
- `HRESP`  in  1  error response.
- `busy`  out  1  `!empty | a_valid | d_valid | a_retry`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- `err_count`  out  8  count of errored writes; saturates at 255.

## Operation
- **FIFO**
  - A push occurs on an edge where `in_valid && in_ready`.
  - A pop occurs on an edge where `HREADY && enable && !empty && !a_retry`.
  - Push and pop may happen on the same edge; `fifo_level` is then unchanged.
  - When full, `in_ready` is 0, even if a pop occurs that cycle.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Pipeline registers:** `a_valid`/`a_byte` hold the address phase; `d_valid`/`d_byte` hold the data phase; `a_retry` is a flag.
- **Edge with `HREADY`=1, normal case:**
  - `d_valid <= a_valid`, `d_byte <= a_byte`.
  - If `a_retry`: `a_valid <= 1`, the same `a_byte` is kept, and `a_retry <= 0`.
  - Otherwise `a_valid <= pop`, and `a_byte <=` FIFO head when popping.
- **Edge with `HREADY`=0:** address and data registers hold. An issued NONSEQ and its `HWDATA` stay stable until accepted.
- **Error, first cycle:** on an edge where `d_valid && HRESP && !HREADY`:
  - `a_retry <= a_valid`, `a_valid <= 0`, so `HTRANS` = IDLE in the second error cycle.
  - `err_count` increments.
  - The errored byte is dropped and not retried.
- **Error, second cycle:** the following `HREADY`=1 edge completes the error. `d_valid <= 0`, and the cancelled byte is re-presented one cycle later via `a_retry`.
- **Steady state:** with a zero-wait slave, the block sustains 1 byte/cycle.
- **Reset (synchronous, any cycle, including mid-transfer):**
  - FIFO is emptied; pointers, `a_valid`, `d_valid`, `a_retry` and `err_count` go to 0.
  - `HTRANS` is 2'b00 and `HWDATA` is 32'h0 from the first edge after `HRESET` is sampled high.
  - Any in-flight data phase is abandoned.
  - Reset values: `in_ready`=0 while `HRESET`=1, then 1; `busy`=0; `fifo_level`=0; `err_count`=0.

## Timing
- **Push at edge E0, zero-wait slave, idle pipeline, `enable`=1:**
  - E0–E1: `busy`=1, `fifo_level`=1.
  - E1 pops the byte; `HTRANS`=NONSEQ from E1 to E2.
  - `HWDATA` holds the byte from E2 to E3.
  - The slave samples the data at E3.
- **Wait states:** each `HREADY`=0 cycle adds one cycle to whichever phase is current.
- **`enable` deassert:** takes effect for pops at the next edge.
- **Error sequence:**
  - Cycle X: `HRESP`=1, `HREADY`=0.
  - Cycle X+1: `HTRANS`=IDLE, `HRESP`=1, `HREADY`=1.
  - Cycle X+2: the retried byte is presented as NONSEQ.
- **`busy`:** falls the cycle after the last data phase completes with `HREADY`=1 and the FIFO is empty.

## Test plan
- **Single byte:** push 0x41 with `HREADY` tied 1 → one NONSEQ two edges later; `HWDATA`=32'h4141_4141 the cycle after; `busy` back to 0 after 3 edges.
- **Full burst:** push 20 bytes continuously with the slave stalled (`HREADY`=0) → `in_ready`=0 after 16 accepted (`fifo_level`=16). After release, bytes appear in order at 1/cycle and `fifo_level` returns to 0.
- **Wait states:** insert 2 `HREADY`=0 cycles in the data phase of the 2nd of 3 bytes → `HWDATA` and the next NONSEQ are stable throughout; byte order is 0x31, 0x32, 0x33 with no duplication.
- **Error on a pipelined stream:** two-cycle ERROR on the data phase of 0x48 while 0x49 is in its address phase → `HTRANS`=IDLE in the 2nd error cycle; 0x49 is re-issued; `err_count`=1; 0x48 is never rewritten.
- **Gating:** `enable`=0 with 4 bytes queued → no NONSEQ and `fifo_level`=4; on `enable`=1, 4 transfers complete; the final byte 0x04 is transferred like any other.
- **Mid-stream reset:** assert `HRESET` during a data phase with 5 bytes queued → `HTRANS`=IDLE, `fifo_level`=0, `err_count`=0 after the edge; after release, a new push of 0x5A is transferred normally.
